mc_control: RTL and testbench
=============================

# mc_control

Multicycle control unit for the 32-bit MIPS datapath. It decodes the instruction register opcode and sequences fetch, decode, execute, memory and writeback over several cycles. It drives every register-enable, memory strobe and datapath mux select, and waits on a memory ready handshake. It also keeps a retired-instruction counter and flags unsupported opcodes. It sits beside the datapath; the memory data register samples memory output on every clock, unconditionally.

## Interface
Parameters:
- `COUNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `op`  input  6  instruction[31:26], taken from the instruction register.
- `zero`  input  1  ALU zero flag.
- `mem_ready`  input  1  memory has completed the current read or write this cycle.
- `mem_read`, `mem_write`  output  1 each  memory strobes.
- `i_or_d`  output  1  memory address select: 0 selects PC, 1 selects ALUOut.
- `ir_write`, `pc_write`, `reg_write`  output  1 each  register load enables.
- `alu_src_a`  output  1  ALU A select: 0 selects PC, 1 selects register A.
- `alu_src_b`  output  2  ALU B select: 00 selects B, 01 selects 4, 10 selects sign-extended immediate, 11 selects sign-extended immediate shifted left 2.
- `alu_op`  output  2  00 ADD, 01 SUB, 10 use the funct field.
- `pc_source`  output  2  00 selects ALU result, 01 selects ALUOut, 10 selects the jump target.
- `reg_dst`  output  1  destination register select: 0 selects rt, 1 selects rd.
- `mem_to_reg`  output  1  writeback data select: 0 selects ALUOut, 1 selects the memory data register.
- `illegal`  output  1  one-cycle pulse on an unsupported opcode.
- `instr_count`  output  COUNT_W  count of retired instructions.
- `state`  output  4  current state, for debug.

## Operation
- Supported opcodes:
  - R-type 0x00
  - lw 0x23
  - sw 0x2B
  - beq 0x04
  - addi 0x08
  - j 0x02
- States and their encodings:
  - FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5
  - R_EX 6, R_WB 7, BRANCH 8, JUMP 9, I_EX 10, I_WB 11
  - Encodings 12 to 15 are unreachable; if entered, the next state is FETCH.
- FETCH:
  - Drives mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write are asserted only in a cycle where mem_ready=1. That cycle advances to DECODE; otherwise the FSM stays in FETCH.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=11, alu_op=00 to precompute the branch target.
  - Next state by opcode: lw and sw go to MEM_ADDR; R-type to R_EX; beq to BRANCH; j to JUMP; addi to I_EX.
  - Any other opcode goes to FETCH and sets `illegal` for exactly the next cycle.
- MEM_ADDR: drives alu_src_a=1, alu_src_b=10, ADD. Next state is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: drives mem_read=1, i_or_d=1. Holds until mem_ready=1, then goes to MEM_WB.
- MEM_WB: drives reg_write=1, reg_dst=0, mem_to_reg=1. The memory data register holds the word captured on the mem_ready edge.
- MEM_WR: drives mem_write=1, i_or_d=1. Holds until mem_ready=1, then goes to FETCH.
- R_EX: drives alu_src_a=1, alu_src_b=00, alu_op=10.
- R_WB: drives reg_write=1, reg_dst=1, mem_to_reg=0.
- I_EX: drives alu_src_a=1, alu_src_b=10, ADD.
- I_WB: drives reg_write=1, reg_dst=0, mem_to_reg=0.
- BRANCH: drives alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, and pc_write=zero.
- JUMP: drives pc_source=10, pc_write=1.
- Any output not listed for a state is 0.
- Retired-instruction counting:
  - instr_count increments by 1 on leaving MEM_WB, R_WB, I_WB, BRANCH or JUMP, and on leaving MEM_WR when mem_ready=1.
  - It wraps modulo 2^COUNT_W.
  - Illegal opcodes are not counted.

## Timing
- While rst_n=0:
  - state=FETCH, instr_count=0, illegal=0.
  - All strobes and enables (mem_read, mem_write, ir_write, pc_write, reg_write) are forced to 0.
  - All mux selects are 0.
- Reset release: the first FETCH cycle is the first rising edge with rst_n=1.
- Outputs are a Moore decode of `state`, with two exceptions: pc_write in BRANCH depends on `zero`, and ir_write/pc_write in FETCH depend on `mem_ready`.
- Cycles per instruction when mem_ready is held at 1: lw 5; sw 4; R-type 4; addi 4; beq 3; j 3. Each cycle mem_ready=0 in a wait state adds one cycle.
- Reset asserted mid-instruction aborts immediately: no partial writeback and no count increment.
- mem_ready=1 outside FETCH, MEM_RD and MEM_WR is ignored.

## Test plan
- Reset with mem_ready=1, then IR op=0x23 (lw): state sequence 0,1,2,3,4,0. reg_write=1 with mem_to_reg=1 only in state 4. instr_count=1.
- sw with mem_ready held low for 3 cycles in MEM_WR: mem_write=1 for 4 cycles. Return to FETCH on the edge after the mem_ready pulse. instr_count increments once.
- beq with zero=1, then beq with zero=0: pc_write=1 in BRANCH only for the first. Both take 3 cycles and both count.
- op=0x3F: `illegal` pulses for exactly 1 cycle, FETCH follows DECODE, and instr_count is unchanged.
- R-type, addi and j back-to-back: R-type shows alu_op=10 and reg_dst=1; addi shows alu_src_b=10 and reg_dst=0; j shows pc_source=10 with pc_write=1. instr_count=3 after 11 cycles.
- Drop rst_n asynchronously mid-MEM_RD: all strobes go to 0 at once, state=0 and instr_count=0. Normal fetch resumes after release.

Source files
------------

// File: rtl/mc_control.sv
// Multicycle MIPS control FSM: sequences the datapath over fetch/decode/execute/memory/writeback.
// Outputs are combinational from state (plus zero/mem_ready); illegal is registered; stalls on mem_ready.
module mc_control #(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         op,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_read,
    output logic               mem_write,
    output logic               i_or_d,
    output logic               ir_write,
    output logic               pc_write,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               illegal,
    output logic [COUNT_W-1:0] instr_count,
    output logic [3:0]         state
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        R_EX     = 4'd6,
        R_WB     = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        I_EX     = 4'd10,
        I_WB     = 4'd11
    } state_e;

    state_e             state_q, state_d;
    logic               illegal_q, illegal_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               retire;

    logic       mem_read_c, mem_write_c, i_or_d_c, ir_write_c, pc_write_c, reg_write_c;
    logic       alu_src_a_c, reg_dst_c, mem_to_reg_c;
    logic [1:0] alu_src_b_c, alu_op_c, pc_source_c;

    always_comb begin
        state_d      = state_q;
        illegal_d    = 1'b0;
        retire       = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        i_or_d_c     = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        alu_src_a_c  = 1'b0;
        alu_src_b_c  = 2'b00;
        alu_op_c     = 2'b00;
        pc_source_c  = 2'b00;
        reg_dst_c    = 1'b0;
        mem_to_reg_c = 1'b0;

        case (state_q)
            FETCH: begin
                mem_read_c  = 1'b1;
                alu_src_b_c = 2'b01;
                ir_write_c  = mem_ready;
                pc_write_c  = mem_ready;
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                alu_src_b_c = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_RTYPE:     state_d = R_EX;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    OP_ADDI:      state_d = I_EX;
                    default: begin
                        state_d   = FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MEM_ADDR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                state_d     = (op == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                mem_read_c = 1'b1;
                i_or_d_c   = 1'b1;
                if (mem_ready) state_d = MEM_WB;
            end
            MEM_WB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 1'b1;
                retire       = 1'b1;
                state_d      = FETCH;
            end
            MEM_WR: begin
                mem_write_c = 1'b1;
                i_or_d_c    = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end
            R_EX: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = 2'b10;
                state_d     = R_WB;
            end
            R_WB: begin
                reg_write_c = 1'b1;
                reg_dst_c   = 1'b1;
                retire      = 1'b1;
                state_d     = FETCH;
            end
            I_EX: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                state_d     = I_WB;
            end
            I_WB: begin
                reg_write_c = 1'b1;
                retire      = 1'b1;
                state_d     = FETCH;
            end
            BRANCH: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = 2'b01;
                pc_source_c = 2'b01;
                pc_write_c  = zero;
                retire      = 1'b1;
                state_d     = FETCH;
            end
            JUMP: begin
                pc_source_c = 2'b10;
                pc_write_c  = 1'b1;
                retire      = 1'b1;
                state_d     = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
        end
    end

    assign count_d = count_q + {{(COUNT_W-1){1'b0}}, retire};

    // Reset gates the decode directly so strobes drop the instant rst_n falls, not at the next edge.
    assign mem_read    = rst_n & mem_read_c;
    assign mem_write   = rst_n & mem_write_c;
    assign i_or_d      = rst_n & i_or_d_c;
    assign ir_write    = rst_n & ir_write_c;
    assign pc_write    = rst_n & pc_write_c;
    assign reg_write   = rst_n & reg_write_c;
    assign alu_src_a   = rst_n & alu_src_a_c;
    assign alu_src_b   = rst_n ? alu_src_b_c : 2'b00;
    assign alu_op      = rst_n ? alu_op_c    : 2'b00;
    assign pc_source   = rst_n ? pc_source_c : 2'b00;
    assign reg_dst     = rst_n & reg_dst_c;
    assign mem_to_reg  = rst_n & mem_to_reg_c;
    assign illegal     = illegal_q;
    assign instr_count = count_q;
    assign state       = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: instruction-path reference model, per-cycle compare, directed plus random traffic.
module tb_mc_control;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [5:0]    op;
    logic          zero, mem_ready;
    logic          mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write;
    logic          alu_src_a, reg_dst, mem_to_reg, illegal;
    logic [1:0]    alu_src_b, alu_op, pc_source;
    logic [CW-1:0] instr_count;
    logic [3:0]    state;

    int tests = 0;
    int fails = 0;

    mc_control #(.COUNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .illegal(illegal), .instr_count(instr_count), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_source;
        logic       reg_dst, mem_to_reg;
    } ctl_t;

    // Each instruction is the list of states visited after DECODE.
    function automatic int path_len(input logic [5:0] o);
        case (o)
            6'h23:               return 3;
            6'h2B, 6'h00, 6'h08: return 2;
            6'h04, 6'h02:        return 1;
            default:             return 0;
        endcase
    endfunction

    function automatic int path_at(input logic [5:0] o, input int i);
        case (o)
            6'h23:   return (i == 0) ? 2 : (i == 1) ? 3 : 4;
            6'h2B:   return (i == 0) ? 2 : 5;
            6'h00:   return (i == 0) ? 6 : 7;
            6'h08:   return (i == 0) ? 10 : 11;
            6'h04:   return 8;
            default: return 9;
        endcase
    endfunction

    function automatic ctl_t exp_ctl(input int s, input logic z, input logic r);
        ctl_t c = '0;
        case (s)
            0:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = r; c.pc_write = r; end
            1:  c.alu_src_b = 2'b11;
            2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            3:  begin c.mem_read = 1; c.i_or_d = 1; end
            4:  begin c.reg_write = 1; c.mem_to_reg = 1; end
            5:  begin c.mem_write = 1; c.i_or_d = 1; end
            6:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
            7:  begin c.reg_write = 1; c.reg_dst = 1; end
            8:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_source = 2'b01; c.pc_write = z; end
            9:  begin c.pc_source = 2'b10; c.pc_write = 1; end
            10: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            11: c.reg_write = 1;
            default: c = '0;
        endcase
        return c;
    endfunction

    int            m_state, m_idx;
    logic [5:0]    m_op;
    logic [CW-1:0] m_count;
    logic          m_ill;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= 0; m_idx <= 0; m_op <= '0; m_count <= '0; m_ill <= 1'b0;
        end else begin
            m_ill <= 1'b0;
            if (m_state == 0) begin
                if (mem_ready) m_state <= 1;
            end else if (m_state == 1) begin
                m_op  <= op;
                m_idx <= 0;
                if (path_len(op) == 0) begin
                    m_ill   <= 1'b1;
                    m_state <= 0;
                end else begin
                    m_state <= path_at(op, 0);
                end
            end else if ((m_state == 3 || m_state == 5) && !mem_ready) begin
                m_state <= m_state;
            end else if (m_idx + 1 >= path_len(m_op)) begin
                m_state <= 0;
                m_count <= m_count + 1'b1;
            end else begin
                m_state <= path_at(m_op, m_idx + 1);
                m_idx   <= m_idx + 1;
            end
        end
    end

    always @(negedge clk) begin
        ctl_t a, e;
        a = {mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write, alu_src_a,
             alu_src_b, alu_op, pc_source, reg_dst, mem_to_reg};
        e = rst_n ? exp_ctl(m_state, zero, mem_ready) : '0;
        tests++;
        if (a !== e || state !== m_state[3:0] || illegal !== m_ill || instr_count !== m_count) begin
            fails++;
            $display("FAIL cycle_compare t=%0t: ctl=%h state=%0d ill=%b cnt=%0d, required ctl=%h state=%0d ill=%b cnt=%0d",
                     $time, a, state, illegal, instr_count, e, m_state, m_ill, m_count);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Runs one instruction from FETCH back to FETCH; waits stall MEM_RD/MEM_WR, noise randomizes don't-care inputs.
    task automatic run_instr(input logic [5:0] o, input logic z, input int waits, input bit noise,
                             output int cyc_n, output int mw_n, output int pw_n, output bit done);
        int w;
        bit seen;
        w = waits; cyc_n = 0; mw_n = 0; pw_n = 0; seen = 0;
        op = o; zero = z;
        do begin
            if (state == 4'd3 || state == 4'd5) begin
                if (w > 0) begin mem_ready = 1'b0; w--; end
                else mem_ready = 1'b1;
            end else begin
                mem_ready = noise ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (noise) zero = 1'($urandom_range(0, 1));
            #1;
            if (mem_write) mw_n++;
            if (pc_write && state != 4'd0) pw_n++;
            @(posedge clk);
            #2;
            cyc_n++;
            if (state != 4'd0) seen = 1;
        end while (!(seen && state == 4'd0) && cyc_n < 60);
        done = seen && (state == 4'd0);
    endtask

    initial begin
        int  c, mw, pw, tot, retired;
        bit  dn;
        logic [3:0] st [6];
        logic [5:0] rw;
        logic [5:0] ops [6];
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};

        rst_n = 1'b0; op = 6'h23; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("reset_state", state, 0);
        check("reset_count", instr_count, 0);
        check("reset_mem_read", mem_read, 0);
        check("reset_ir_write", ir_write, 0);
        rst_n = 1'b1;

        // lw with memory always ready
        rw = '0;
        st[0] = state; rw[0] = reg_write & mem_to_reg;
        for (int i = 1; i < 6; i++) begin
            cyc();
            st[i] = state;
            rw[i] = reg_write & mem_to_reg;
        end
        check("lw_s0", st[0], 0); check("lw_s1", st[1], 1); check("lw_s2", st[2], 2);
        check("lw_s3", st[3], 3); check("lw_s4", st[4], 4); check("lw_s5", st[5], 0);
        check("lw_wb_only_in_4", rw, 6'b010000);
        check("lw_count", instr_count, 1);

        run_instr(6'h2B, 1'b0, 3, 0, c, mw, pw, dn);
        check("sw_cycles", c, 7);
        check("sw_mem_write_cycles", mw, 4);
        check("sw_count", instr_count, 2);

        run_instr(6'h04, 1'b1, 0, 0, c, mw, pw, dn);
        check("beq_taken_cycles", c, 3);
        check("beq_taken_pc_write", pw, 1);
        run_instr(6'h04, 1'b0, 0, 0, c, mw, pw, dn);
        check("beq_not_taken_cycles", c, 3);
        check("beq_not_taken_pc_write", pw, 0);
        check("beq_count", instr_count, 4);

        run_instr(6'h3F, 1'b0, 0, 0, c, mw, pw, dn);
        check("illegal_cycles", c, 2);
        check("illegal_pulse", illegal, 1);
        check("illegal_count", instr_count, 4);
        mem_ready = 1'b0;
        cyc();
        check("illegal_pulse_end", illegal, 0);

        tot = 0;
        run_instr(6'h00, 1'b0, 0, 0, c, mw, pw, dn); tot += c;
        run_instr(6'h08, 1'b0, 0, 0, c, mw, pw, dn); tot += c;
        run_instr(6'h02, 1'b0, 0, 0, c, mw, pw, dn); tot += c;
        check("rij_cycles", tot, 11);
        check("rij_count", instr_count, 7);

        // asynchronous reset in the middle of a load
        op = 6'h23; mem_ready = 1'b1;
        cyc(); cyc();
        mem_ready = 1'b0;
        cyc();
        check("pre_abort_state", state, 3);
        #1 rst_n = 1'b0;
        #1;
        check("abort_state", state, 0);
        check("abort_count", instr_count, 0);
        check("abort_mem_read", mem_read, 0);
        check("abort_i_or_d", i_or_d, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        run_instr(6'h23, 1'b0, 0, 0, c, mw, pw, dn);
        check("resume_lw_cycles", c, 5);
        check("resume_count", instr_count, 1);

        retired = 1;
        for (int n = 0; n < 400; n++) begin
            logic [5:0] o;
            int k;
            k = $urandom_range(0, 6);
            o = (k == 6) ? 6'($urandom) : ops[k];
            if (path_len(o) != 0) retired++;
            run_instr(o, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1, c, mw, pw, dn);
            check("random_instr_done", dn, 1);
        end
        check("random_retired_wrap", instr_count, retired % (1 << CW));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

endmodule
